// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue stage in front of the 4-bit ALU. Instructions are buffered in a small
//   FIFO, executed one at a time (operand read -> ALU -> writeback), and results
//   are written back into a 4x4-bit register file. Add/sub carries are kept in
//   carry_flag.
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        instruction handshake (in_ready = !full)
//   in_ld,in_op,in_ra,in_rb,
//   in_rd,in_imm             instruction fields
//   alu_op/alu_a/alu_b       ALU operands, zero outside EXEC
//   alu_c/alu_carry          ALU result
//   wb_valid/wb_rd/wb_data   one-cycle writeback pulse
//   carry_flag               last add/sub carry
//   busy                     work in flight or queued
//   dbg_idx/dbg_data         combinational register-file read port
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_ld,
    input  logic [2:0] in_op,
    input  logic [1:0] in_ra,
    input  logic [1:0] in_rb,
    input  logic [1:0] in_rd,
    input  logic [3:0] in_imm,
    output logic [2:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    input  logic       alu_carry,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data,
    output logic       carry_flag,
    output logic       busy,
    input  logic [1:0] dbg_idx,
    output logic [3:0] dbg_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic       ld;
        logic [2:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] rd;
        logic [3:0] imm;
    } instr_t;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    // ---------------- instruction FIFO ----------------
    instr_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    instr_t        head, in_instr;

    state_t        state;
    instr_t        instr;
    logic [3:0]    res;
    logic          cy;
    logic [3:0][3:0] rf;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // A pop never frees space for a push in the same cycle: in_ready
    // depends only on occupancy.
    assign push     = in_valid && !full;
    // The FSM takes the next instruction whenever it is idle or finishing a
    // writeback, which is what gives one load per cycle.
    assign pop      = !empty && (state == IDLE || state == WB);
    assign head     = mem[rptr];
    assign in_instr = '{ld: in_ld, op: in_op, ra: in_ra, rb: in_rb,
                        rd: in_rd, imm: in_imm};

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= in_instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- execution FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            instr      <= '0;
            res        <= '0;
            cy         <= 1'b0;
            rf         <= '0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE, WB: begin
                    if (state == WB) begin
                        rf[instr.rd] <= res;
                        // only add (0) and sub (1) update the flag
                        if (!instr.ld && instr.op[2:1] == 2'b00)
                            carry_flag <= cy;
                    end
                    if (pop) begin
                        instr <= head;
                        // loads write the immediate; for ALU ops res is
                        // overwritten in EXEC
                        res   <= head.imm;
                        state <= head.ld ? WB : EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    res   <= alu_c;
                    cy    <= alu_carry;
                    state <= WB;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state. Register reads in EXEC
    // see the prior WB because the write lands at the end of the WB cycle.
    always_comb begin
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        wb_valid = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        if (state == EXEC) begin
            alu_op = instr.op;
            alu_a  = rf[instr.ra];
            alu_b  = rf[instr.rb];
        end
        if (state == WB) begin
            wb_valid = 1'b1;
            wb_rd    = instr.rd;
            wb_data  = res;
        end
    end

    assign busy     = (state != IDLE) || !empty;
    assign dbg_data = rf[dbg_idx];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ld = 1'b0;
    logic [2:0] in_op = '0;
    logic [1:0] in_ra = '0, in_rb = '0, in_rd = '0;
    logic [3:0] in_imm = '0;
    logic       in_ready;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       alu_carry;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
    logic       carry_flag, busy;
    logic [1:0] dbg_idx = '0;
    logic [3:0] dbg_data;

    alu_issue_ctrl #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_op(in_op),
        .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_carry(alu_carry),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .carry_flag(carry_flag), .busy(busy),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // team ALU: sub carry is a borrow
    always_comb begin
        alu_c = '0;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin alu_c = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            3'd2: alu_c = alu_a & alu_b;
            3'd3: alu_c = alu_a | alu_b;
            3'd4: alu_c = ~alu_a;
            3'd5: alu_c = alu_a ^ alu_b;
            3'd6: alu_c = ~(alu_a & alu_b);
            default: alu_c = ~(alu_a | alu_b);
        endcase
    end

    int tests = 0, fails = 0;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Transaction-level model: because execution is strictly in order, the
    // result of every instruction can be computed at the moment it is accepted.
    typedef struct {int rd; int data; bit setcy; bit cy;} wb_t;
    wb_t exp_q[$];
    int  m_rf[4];
    int  ret_rf[4];
    bit  ret_cy;
    int  just_pushed;
    bit  saw_full;

    function automatic void model_push(bit ld, int op, int ra, int rb, int rd, int imm);
        int a = m_rf[ra];
        int b = m_rf[rb];
        int r = 0;
        bit c = 0, s = 0;
        if (ld) r = imm;
        else case (op)
            0: begin r = a + b; c = (r > 15); s = 1; end
            1: begin r = a - b; c = (a < b); s = 1; end
            2: r = a & b;
            3: r = a | b;
            4: r = ~a;
            5: r = a ^ b;
            6: r = ~(a & b);
            default: r = ~(a | b);
        endcase
        r = r & 15;
        m_rf[rd] = r;
        exp_q.push_back('{rd, r, s, c});
        just_pushed = 1;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin m_rf[i] = 0; ret_rf[i] = 0; end
        ret_cy = 0;
        just_pushed = 0;
    endfunction

    // Compare process: every cycle, 2 time units after the falling edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            just_pushed = 0;
        end else begin
            chk("carry_flag", carry_flag, ret_cy);
            chk("dbg_data", dbg_data, ret_rf[dbg_idx]);
            chk("busy", busy, (exp_q.size() - just_pushed) > 0);
            just_pushed = 0;
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 1, 0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                    ret_rf[e.rd] = e.data;
                    if (e.setcy) ret_cy = e.cy;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    // with in_valid still high (back-to-back capable).
    task automatic send(bit ld, int op, int ra, int rb, int rd, int imm);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1; in_ld = ld; in_op = op[2:0];
        in_ra = ra[1:0]; in_rb = rb[1:0]; in_rd = rd[1:0]; in_imm = imm[3:0];
        while (!done) begin
            #1;
            if (in_ready) begin
                model_push(ld, op, ra, rb, rd, imm);
                done = 1;
            end else begin
                saw_full = 1;
            end
            @(negedge clk);
            n++;
            if (!done && n > 50) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic wait_n(int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(int idx, int e, string nm);
        dbg_idx = idx[1:0];
        #1;
        chk(nm, dbg_data, e);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_alu_a", alu_a, 0);
        for (int i = 0; i < 4; i++) peek(i, 0, "rst_rf");
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_checks();
    endtask

    initial begin
        int n;
        model_reset();
        saw_full = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        reset_checks();

        // loads and one add with exact latency
        send(1, 0, 0, 0, 0, 8); in_valid = 1'b0;
        @(negedge clk);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_rd", wb_rd, 0);
        chk("ld_wb_data", wb_data, 8);
        send(1, 0, 0, 0, 1, 4); wait_n(2);
        dbg_idx = 2'd2;
        send(0, 0, 0, 1, 2, 0); in_valid = 1'b0;
        chk("add_k1_alu_a", alu_a, 0);
        chk("add_k1_wb", wb_valid, 0);
        @(negedge clk);
        chk("add_exec_op", alu_op, 0);
        chk("add_exec_a", alu_a, 8);
        chk("add_exec_b", alu_b, 4);
        @(negedge clk);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_rd", wb_rd, 2);
        chk("add_wb_data", wb_data, 12);
        @(negedge clk);
        chk("add_rf", dbg_data, 12);
        chk("add_carry", carry_flag, 0);
        chk("add_busy", busy, 0);

        // carry from overflow, then kept by a logic op
        send(1, 0, 0, 0, 0, 8);
        send(0, 0, 0, 0, 3, 0); wait_n(6);
        peek(3, 0, "ovf_r3");
        chk("ovf_carry", carry_flag, 1);
        send(0, 2, 0, 3, 2, 0); wait_n(5);
        peek(2, 0, "and_r2");
        chk("and_carry_kept", carry_flag, 1);

        // add clears carry, sub borrow sets it
        send(0, 0, 1, 1, 3, 0); wait_n(5);
        chk("add_clr_carry", carry_flag, 0);
        send(0, 1, 1, 0, 2, 0); wait_n(5);
        peek(2, 12, "sub_r2");
        chk("sub_borrow", carry_flag, 1);

        // back-to-back stream filling the FIFO
        saw_full = 0;
        send(0, 5, 0, 1, 2, 0);
        send(0, 3, 2, 0, 3, 0);
        send(0, 0, 1, 1, 1, 0);
        send(0, 2, 0, 3, 0, 0);
        send(0, 5, 2, 3, 1, 0);
        wait_n(14);
        chk("fifo_full_seen", saw_full, 1);
        peek(2, 12, "b2b_r2");
        peek(3, 12, "b2b_r3");
        peek(0, 8, "b2b_r0");
        peek(1, 0, "b2b_r1");

        // reset while an add is executing
        send(0, 0, 0, 0, 1, 0); in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_exec_a", alu_a, 8);
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_checks();
        wait_n(4);

        // randomized traffic with a mid-run reset
        for (int it = 0; it < 400; it++) begin
            dbg_idx = 2'($urandom);
            if (it == 200) begin
                pulse_reset();
            end else if ($urandom_range(0, 9) < 6) begin
                send($urandom_range(0, 3) == 0, $urandom_range(0, 7),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 15));
            end else begin
                wait_n(1);
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        wait_n(2);
        chk("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
